// File: rtl/expr_paren_check_pkg.sv
// Shared definitions for the expression-checking blocks.
//   state_e : FSM states of the streaming validator
//   cls_e   : character classes produced by expr_char_class
//   ASCII_* : character constants used by the classifier
package expr_pkg;

  typedef enum logic [1:0] {
    S_EXPECT,
    S_NUM,
    S_CLOSE,
    S_ERR
  } state_e;

  typedef enum logic [2:0] {
    C_DIGIT,
    C_OP,
    C_LP,
    C_RP,
    C_OTHER
  } cls_e;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_LP    = 8'h28;
  localparam logic [7:0] ASCII_RP    = 8'h29;

endpackage

// File: rtl/expr_paren_check_if.sv
// Character stream in / verdict out bundle for expr_paren_check.
//   in_valid, in : one ASCII character per accepted cycle (master -> slave)
//   out          : accepted prefix is a complete valid expression
//   err          : sticky, prefix can never become valid
//   depth        : current count of open parentheses
interface expr_paren_check_if #(
  parameter int MAX_DEPTH = 4
);
  localparam int DW = $clog2(MAX_DEPTH + 1);

  logic          in_valid;
  logic [7:0]    in;
  logic          out;
  logic          err;
  logic [DW-1:0] depth;

  modport master (output in_valid, output in, input out, input err, input depth);
  modport slave  (input in_valid, input in, output out, output err, output depth);
endinterface

// File: rtl/expr_paren_check_char_class.sv
// Combinational ASCII character classifier shared by the expression blocks.
//   in_ch : ASCII character
//   cls   : DIGIT / OP / LP / RP / OTHER ('-' is an OP only when ALLOW_MINUS=1)
module expr_char_class
  import expr_pkg::*;
#(
  parameter bit ALLOW_MINUS = 1'b0
) (
  input  logic [7:0] in_ch,
  output cls_e       cls
);

  always_comb begin
    cls = C_OTHER;
    if (in_ch >= ASCII_0 && in_ch <= ASCII_9) begin
      cls = C_DIGIT;
    end else if (in_ch == ASCII_PLUS || in_ch == ASCII_STAR ||
                 (ALLOW_MINUS && in_ch == ASCII_MINUS)) begin
      cls = C_OP;
    end else if (in_ch == ASCII_LP) begin
      cls = C_LP;
    end else if (in_ch == ASCII_RP) begin
      cls = C_RP;
    end
  end

endmodule

// File: rtl/expr_paren_check.sv
// Streaming validator for arithmetic expressions with parentheses.
//   clk : rising-edge clock
//   clr : synchronous active-high clear, wins over bus.in_valid
//   bus : expr_paren_check_if slave (in_valid/in in, out/err/depth out)
// All outputs are registered; a character accepted at edge N is reflected
// right after edge N.
module expr_paren_check
  import expr_pkg::*;
#(
  parameter int MAX_DEPTH   = 4,
  parameter int MULTI_DIGIT = 1,
  parameter int ALLOW_MINUS = 0
) (
  input  logic                  clk,
  input  logic                  clr,
  expr_paren_check_if.slave     bus
);

  localparam int DW = $clog2(MAX_DEPTH + 1);

  cls_e          cls;
  state_e        state_q, state_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          out_q, out_d;
  logic          err_q, err_d;

  expr_char_class #(
    .ALLOW_MINUS(ALLOW_MINUS != 0)
  ) u_class (
    .in_ch(bus.in),
    .cls  (cls)
  );

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    if (bus.in_valid) begin
      unique case (state_q)
        S_EXPECT: begin
          unique case (cls)
            C_DIGIT: state_d = S_NUM;
            C_LP: begin
              if (depth_q < DW'(MAX_DEPTH)) depth_d = depth_q + DW'(1);
              else                          state_d = S_ERR;
            end
            default: state_d = S_ERR;
          endcase
        end
        S_NUM: begin
          unique case (cls)
            C_DIGIT: state_d = (MULTI_DIGIT != 0) ? S_NUM : S_ERR;
            C_OP:    state_d = S_EXPECT;
            C_RP: begin
              if (depth_q != '0) begin
                depth_d = depth_q - DW'(1);
                state_d = S_CLOSE;
              end else begin
                state_d = S_ERR;
              end
            end
            default: state_d = S_ERR;
          endcase
        end
        S_CLOSE: begin
          unique case (cls)
            C_OP: state_d = S_EXPECT;
            C_RP: begin
              if (depth_q != '0) depth_d = depth_q - DW'(1);
              else               state_d = S_ERR;
            end
            default: state_d = S_ERR;
          endcase
        end
        default: state_d = state_q;  // ERR absorbs; depth stays frozen
      endcase
    end
    // Verdicts are computed from the next state so they register together.
    out_d = (state_d == S_NUM || state_d == S_CLOSE) && (depth_d == '0);
    err_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_EXPECT;
      depth_q <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.err   = err_q;
  assign bus.depth = depth_q;

endmodule

// File: tb/tb_expr_paren_check.sv
module tb_expr_paren_check;

  logic       clk = 1'b0;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_ch;

  int checks = 0;
  int errors = 0;

  // Accepted characters since the last clear; all DUTs see the same stream.
  logic [7:0] acc[$];

  always #5 clk = ~clk;

  // Four configurations driven in parallel from one stimulus stream.
  expr_paren_check_if #(.MAX_DEPTH(4)) if_def ();
  expr_paren_check_if #(.MAX_DEPTH(4)) if_sd  ();
  expr_paren_check_if #(.MAX_DEPTH(2)) if_d2  ();
  expr_paren_check_if #(.MAX_DEPTH(4)) if_am  ();

  assign if_def.in_valid = in_valid;  assign if_def.in = in_ch;
  assign if_sd.in_valid  = in_valid;  assign if_sd.in  = in_ch;
  assign if_d2.in_valid  = in_valid;  assign if_d2.in  = in_ch;
  assign if_am.in_valid  = in_valid;  assign if_am.in  = in_ch;

  expr_paren_check #(.MAX_DEPTH(4), .MULTI_DIGIT(1), .ALLOW_MINUS(0))
    u_def (.clk(clk), .clr(clr), .bus(if_def.slave));
  expr_paren_check #(.MAX_DEPTH(4), .MULTI_DIGIT(0), .ALLOW_MINUS(0))
    u_sd  (.clk(clk), .clr(clr), .bus(if_sd.slave));
  expr_paren_check #(.MAX_DEPTH(2), .MULTI_DIGIT(1), .ALLOW_MINUS(0))
    u_d2  (.clk(clk), .clr(clr), .bus(if_d2.slave));
  expr_paren_check #(.MAX_DEPTH(4), .MULTI_DIGIT(1), .ALLOW_MINUS(1))
    u_am  (.clk(clk), .clr(clr), .bus(if_am.slave));

  // Reference: scan the whole accepted string with token-adjacency rules and
  // a running parenthesis balance; the first illegal character poisons it.
  function automatic void eval(input int maxd, input bit multi, input bit minus,
                               output bit o, output bit e, output int d);
    int bal = 0;
    bit p_open = 1'b1, p_dig = 1'b0, p_rp = 1'b0;
    bit ok, is_dig, is_op;
    e = 1'b0;
    foreach (acc[i]) begin
      is_dig = (acc[i] >= "0" && acc[i] <= "9");
      is_op  = (acc[i] == "+" || acc[i] == "*" || (minus && acc[i] == "-"));
      if (is_dig)              ok = p_open || (p_dig && multi);
      else if (is_op)          ok = p_dig || p_rp;
      else if (acc[i] == "(")  ok = p_open && (bal < maxd);
      else if (acc[i] == ")")  ok = (p_dig || p_rp) && (bal > 0);
      else                     ok = 1'b0;
      if (!ok) begin
        e = 1'b1;
        break;
      end
      if (acc[i] == "(") bal++;
      if (acc[i] == ")") bal--;
      p_open = is_op || (acc[i] == "(");
      p_dig  = is_dig;
      p_rp   = (acc[i] == ")");
    end
    d = bal;
    o = !e && (p_dig || p_rp) && (bal == 0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_cfg(input string name, input int maxd, input bit multi,
                           input bit minus, input logic o, input logic e,
                           input logic [31:0] d);
    bit eo, ee;
    int ed;
    eval(maxd, multi, minus, eo, ee, ed);
    check({name, ".out"},   {31'd0, o}, {31'd0, eo});
    check({name, ".err"},   {31'd0, e}, {31'd0, ee});
    check({name, ".depth"}, d, ed);
  endtask

  // One clock: drive at negedge, sample 1 time unit after the rising edge.
  task automatic step(input bit v, input logic [7:0] c, input bit cl);
    @(negedge clk);
    in_valid = v;
    in_ch    = c;
    clr      = cl;
    @(posedge clk);
    #1;
    if (cl)     acc.delete();
    else if (v) acc.push_back(c);
    check_cfg("def", 4, 1'b1, 1'b0, if_def.out, if_def.err, 32'(if_def.depth));
    check_cfg("sd",  4, 1'b0, 1'b0, if_sd.out,  if_sd.err,  32'(if_sd.depth));
    check_cfg("d2",  2, 1'b1, 1'b0, if_d2.out,  if_d2.err,  32'(if_d2.depth));
    check_cfg("am",  4, 1'b1, 1'b1, if_am.out,  if_am.err,  32'(if_am.depth));
  endtask

  task automatic feed(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0);
  endtask

  string charset = "0123456789+*-()(()) x";

  initial begin
    clr      = 1'b1;
    in_valid = 1'b0;
    in_ch    = 8'h00;
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    // Empty input after reset.
    check("reset.out", {31'd0, if_def.out}, 32'd0);
    check("reset.err", {31'd0, if_def.err}, 32'd0);

    feed("12+3");
    check("multi.out", {31'd0, if_def.out}, 32'd1);
    check("single.err", {31'd0, if_sd.err}, 32'd1);
    step(1'b0, 8'h00, 1'b1);

    feed("((7)*2)");
    check("nest.out", {31'd0, if_def.out}, 32'd1);
    step(1'b0, 8'h00, 1'b1);

    feed("(((");
    check("ovf.err", {31'd0, if_d2.err}, 32'd1);
    check("ovf.depth", 32'(if_d2.depth), 32'd2);
    step(1'b0, 8'h00, 1'b1);

    feed("5)");
    check("unf.depth", 32'(if_def.depth), 32'd0);
    step(1'b0, 8'h00, 1'b1);

    feed("4-9");
    check("minus.out", {31'd0, if_am.out}, 32'd1);
    check("nominus.err", {31'd0, if_def.err}, 32'd1);
    step(1'b0, 8'h00, 1'b1);

    // Toggling in_valid, then clr with a live character that must be dropped.
    step(1'b1, "(", 1'b0);
    step(1'b0, "9", 1'b0);
    step(1'b1, "3", 1'b0);
    step(1'b0, ")", 1'b0);
    step(1'b1, "5", 1'b1);
    check("clr.depth", 32'(if_def.depth), 32'd0);
    step(1'b1, "8", 1'b0);
    check("after_clr.out", {31'd0, if_def.out}, 32'd1);

    // Random characters biased toward legal tokens, with sparse clears.
    for (int n = 0; n < 600; n++) begin
      int idx;
      idx = $urandom_range(0, charset.len() - 1);
      step($urandom_range(0, 3) != 0, charset[idx], $urandom_range(0, 19) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/expr_paren_check.md
# expr_paren_check

Streaming validator for arithmetic expressions, one ASCII character per accepted cycle. It generalises the single-digit `+`/`*` checker in three ways: optional multi-digit operands, parenthesised sub-expressions nested up to a parametrised depth, and an optional `-` operator. It sits behind the character-input front end. Its registered `out` tells downstream logic whether the characters accepted since the last clear form a complete, well-formed expression.

## Interface
- `MAX_DEPTH`, default 4: maximum parenthesis nesting, legal range 1..15.
- `MULTI_DIGIT`, default 1: 1 lets a run of digits form one operand; 0 allows single-digit operands only.
- `ALLOW_MINUS`, default 0: 1 adds `-` to the operator set `+`, `*`.
- `DW`: local parameter, `$clog2(MAX_DEPTH+1)`.
- `clk`  in  1: the only clock; all state changes on its rising edge.
- `clr`  in  1: reset, synchronous and active-high; has priority over `in_valid`.
- `in_valid`  in  1: `in` carries a character this cycle.
- `in`  in  8: ASCII character.
- `out`  out  1: the accepted prefix is a complete valid expression.
- `err`  out  1: sticky; the prefix can never become valid.
- `depth`  out  DW: current count of open parentheses.

## Operation
- Character classes:
  - DIGIT: `"0"`..`"9"`.
  - OP: `+` or `*`, plus `-` only when `ALLOW_MINUS`=1.
  - LP: `(`.
  - RP: `)`.
  - OTHER: anything else, including space.
- States:
  - EXPECT: an operand is expected. This is the reset state, and the state after an OP or LP.
  - NUM: the last character was a digit.
  - CLOSE: the last character was `)`.
  - ERR: absorbing.
- Transitions, taken only when `in_valid`=1:
  - EXPECT:
    - DIGIT goes to NUM.
    - LP: if `depth`<`MAX_DEPTH`, `depth`+1 and stay in EXPECT; otherwise go to ERR.
    - OP, RP or OTHER goes to ERR.
  - NUM:
    - DIGIT stays in NUM if `MULTI_DIGIT`=1; otherwise goes to ERR.
    - OP goes to EXPECT.
    - RP: if `depth`>0, `depth`−1 and go to CLOSE; otherwise go to ERR.
    - LP or OTHER goes to ERR.
  - CLOSE:
    - OP goes to EXPECT.
    - RP: if `depth`>0, `depth`−1 and stay in CLOSE; otherwise go to ERR.
    - DIGIT, LP or OTHER goes to ERR.
  - ERR: every character is ignored; only `clr` leaves this state.
- `out` next value: 1 when the next state is NUM or CLOSE and the next `depth`=0; 0 otherwise.
- `err` next value: 1 when the next state is ERR.
- Going to ERR leaves `depth` frozen at its last value.
- Operand values are never computed; the block checks syntax only.

## Timing
- Outputs are all registered. They reflect every character accepted up to and including the previous rising edge. There is no combinational path from `in` to any output.
- Latency: a character accepted at edge N shows on the outputs right after edge N.
- `in_valid`=0: state, `depth` and all outputs hold.
- `clr`=1 at an edge gives state EXPECT, `depth`=0, `out`=0, `err`=0, whatever `in_valid`/`in` are.
  - This holds mid-expression and in ERR.
  - The character presented in the same cycle as `clr` is discarded.
- Overflow: LP at `depth`=`MAX_DEPTH` goes to ERR, and `depth` never exceeds `MAX_DEPTH`.
- Underflow: RP at `depth`=0 goes to ERR, and `depth` never wraps.
- `out` and `err` are never 1 together.
- Empty input after reset gives `out`=0 and `err`=0.

## Structure
- Shared package `expr_pkg`:
  - the state enum (EXPECT, NUM, CLOSE, ERR);
  - the character-class enum (DIGIT, OP, LP, RP, OTHER);
  - ASCII constants for `"0"`, `"9"`, `+`, `*`, `-`, `(`, `)`.
- Sub-module `expr_char_class`: a combinational classifier that takes `in` and `ALLOW_MINUS` and produces the class.
- The top level holds the FSM and the `depth` counter.
- The same classifier is reused by the other expression blocks.

## Test plan
- Defaults; feed `1`,`2`,`+`,`3` → `out` sequence 1,1,0,1; `err` stays 0; `depth` stays 0.
- `MULTI_DIGIT`=0; feed `1`,`2` → after `2`, `err`=1 and `out`=0. Then feed `+` → nothing changes.
- Defaults; feed `(`,`(`,`7`,`)`,`*`,`2`,`)` → `depth` 1,2,2,1,1,1,0; `out` is 1 only after the final `)`.
- `MAX_DEPTH`=2; feed `(`,`(`,`(` → `err`=1 after the third `(`, with `depth` frozen at 2. Also feed `5`,`)` → `err`=1 on `)` and `depth` stays 0.
- Feed `4`,`-`:
  - with `ALLOW_MINUS`=0 → `err`=1 after `-`;
  - with `ALLOW_MINUS`=1 → `out`=0, `err`=0; then `9` → `out`=1.
- Feed `(`,`3` with `in_valid` toggling, then assert `clr` together with `in_valid`=1 and `in`=`5` → after the `clr` edge, `depth`=0, `out`=0, `err`=0, and the `5` is ignored. The next accepted `8` → `out`=1.
